// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads the instruction ROM and buffers
// {pc, instr} pairs in a small prefetch FIFO feeding decode over valid/ready.
module instr_fetch #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [DATA_W-1:0]          imem_instr,
  input  logic                       fetch_en,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [DATA_W-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              pop;
  logic              push;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop  = (count != '0) & out_ready;
  assign push = fetch_en & ~redirect_valid & ((count < CNT_W'(DEPTH)) | pop);

  assign imem_addr  = fetch_pc;
  assign fifo_count = count;
  assign out_valid  = (count != '0);
  assign out_pc     = out_valid ? pc_mem[rd_ptr]    : '0;
  assign out_instr  = out_valid ? instr_mem[rd_ptr] : '0;

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= imem_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= ADDR_W'(RESET_PC);
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch; the ROM returns 0xA000_0000 + address.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        fetch_en;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pc;
  logic [31:0] out_instr;
  logic [2:0]  fifo_count;

  int checks = 0;
  int passed = 0;

  instr_fetch #(.ADDR_W(8), .DATA_W(32), .DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk),
    .rst(rst),
    .imem_addr(imem_addr),
    .imem_instr(imem_instr),
    .fetch_en(fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_instr(out_instr),
    .fifo_count(fifo_count)
  );

  assign imem_instr = 32'hA000_0000 + {24'h0, imem_addr};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic r, input logic en, input logic rdy,
                               input logic rv, input logic [7:0] rpc);
    rst            = r;
    fetch_en       = en;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    assert (got === exp) passed = passed + 1;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    checkOutput("reset_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("reset_pc", {24'h0, out_pc}, 32'h0);
    checkOutput("reset_instr", out_instr, 32'h0);
    checkOutput("reset_count", {29'h0, fifo_count}, 32'h0);
    checkOutput("reset_addr", {24'h0, imem_addr}, 32'h0);

    // Streaming: one instruction per cycle, consecutive pcs
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput("stream_valid", {31'h0, out_valid}, 32'h1);
      checkOutput("stream_pc", {24'h0, out_pc}, i);
      checkOutput("stream_instr", out_instr, 32'hA000_0000 + i);
      checkOutput("stream_count", {29'h0, fifo_count}, 32'h1);
      checkOutput("stream_addr", {24'h0, imem_addr}, i + 1);
    end

    // Restart at 0, then backpressure for 8 cycles
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    step();
    checkOutput("flush_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("flush_addr", {24'h0, imem_addr}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      step();
      checkOutput("bp_count", {29'h0, fifo_count}, (k < 4) ? k : 4);
      checkOutput("bp_addr", {24'h0, imem_addr}, (k < 4) ? k : 4);
      checkOutput("bp_pc", {24'h0, out_pc}, 32'h0);
      checkOutput("bp_instr", out_instr, 32'hA000_0000);
    end

    // Release: full FIFO with push and pop every cycle
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    for (int j = 1; j <= 7; j++) begin
      step();
      checkOutput("rel_pc", {24'h0, out_pc}, j);
      checkOutput("rel_instr", out_instr, 32'hA000_0000 + j);
      checkOutput("rel_count", {29'h0, fifo_count}, 32'h4);
      checkOutput("rel_addr", {24'h0, imem_addr}, 4 + j);
    end

    // Drain with fetch disabled
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int d = 1; d <= 4; d++) begin
      step();
      checkOutput("drain_count", {29'h0, fifo_count}, 4 - d);
      checkOutput("drain_addr", {24'h0, imem_addr}, 32'd11);
      checkOutput("drain_pc", {24'h0, out_pc}, (d < 4) ? 7 + d : 0);
    end
    checkOutput("drain_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("drain_instr", out_instr, 32'h0);

    // Redirect while three entries are held
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step();
    step();
    step();
    checkOutput("pre_redir_count", {29'h0, fifo_count}, 32'h3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h40);
    step();
    checkOutput("redir_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("redir_count", {29'h0, fifo_count}, 32'h0);
    checkOutput("redir_addr", {24'h0, imem_addr}, 32'h40);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    step();
    checkOutput("redir_out_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("redir_out_pc", {24'h0, out_pc}, 32'h40);
    checkOutput("redir_out_instr", out_instr, 32'hA000_0040);

    // PC wraps from 0xFF to 0x00
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'hFE);
    step();
    checkOutput("wrap_redir_addr", {24'h0, imem_addr}, 32'hFE);
    checkOutput("wrap_redir_valid", {31'h0, out_valid}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    step();
    checkOutput("wrap_pc0", {24'h0, out_pc}, 32'hFE);
    checkOutput("wrap_instr0", out_instr, 32'hA000_00FE);
    step();
    checkOutput("wrap_pc1", {24'h0, out_pc}, 32'hFF);
    checkOutput("wrap_instr1", out_instr, 32'hA000_00FF);
    checkOutput("wrap_addr1", {24'h0, imem_addr}, 32'h00);
    step();
    checkOutput("wrap_pc2", {24'h0, out_pc}, 32'h00);
    checkOutput("wrap_instr2", out_instr, 32'hA000_0000);
    step();
    checkOutput("wrap_pc3", {24'h0, out_pc}, 32'h01);
    checkOutput("wrap_addr3", {24'h0, imem_addr}, 32'h02);

    // Fill, then reset and redirect together: reset wins
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step();
    step();
    step();
    checkOutput("full_count", {29'h0, fifo_count}, 32'h4);
    checkOutput("full_addr", {24'h0, imem_addr}, 32'h05);
    step();
    checkOutput("full_hold_count", {29'h0, fifo_count}, 32'h4);
    checkOutput("full_hold_addr", {24'h0, imem_addr}, 32'h05);
    checkOutput("full_hold_pc", {24'h0, out_pc}, 32'h01);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h33);
    step();
    checkOutput("rst_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst_addr", {24'h0, imem_addr}, 32'h0);
    checkOutput("rst_pc", {24'h0, out_pc}, 32'h0);
    checkOutput("rst_instr", out_instr, 32'h0);
    checkOutput("rst_count", {29'h0, fifo_count}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    step();
    checkOutput("post_rst_valid", {31'h1 & 31'h0, out_valid}, 32'h1);
    checkOutput("post_rst_pc", {24'h0, out_pc}, 32'h0);
    checkOutput("post_rst_instr", out_instr, 32'hA000_0000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit of the single-cycle/pipelined CPU; the reading end of the 256×32 instruction ROM. It owns the program counter, drives the ROM word address, captures the combinationally returned instruction word into a small prefetch FIFO, and hands {pc, instr} pairs to decode over a valid/ready handshake. Branch/jump redirects from execute flush the FIFO and restart fetch at the new address.

## Interface

- ADDR_W, 8, ROM word-address width; PC counts words.
- DATA_W, 32, instruction width.
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2.
- RESET_PC, 0, first fetch address after reset.

- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  ADDR_W  ROM word address; equals fetch_pc register.
- imem_instr  input  DATA_W  ROM data; combinational function of imem_addr, valid same cycle.
- fetch_en  input  1  1 = fetch permitted this cycle; 0 = hold PC, no push.
- redirect_valid  input  1  flush and restart request from execute.
- redirect_pc  input  ADDR_W  restart address, sampled when redirect_valid=1.
- out_valid  output  1  head entry available to decode.
- out_ready  input  1  decode accepts head entry this cycle.
- out_pc  output  ADDR_W  word address of head instruction.
- out_instr  output  DATA_W  head instruction word.
- fifo_count  output  $clog2(DEPTH)+1  occupied entries, for debug/perf counters.

## Operation

- State: fetch_pc (ADDR_W), FIFO storage DEPTH×(ADDR_W+DATA_W), wr_ptr, rd_ptr, count.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (count < DEPTH | pop). Full FIFO with simultaneous pop accepts the push; count unchanged.
- On push: write {fetch_pc, imem_instr} at wr_ptr; wr_ptr++; fetch_pc <= fetch_pc + 1 modulo 2^ADDR_W (255 wraps to 0, no flag).
- On pop: rd_ptr++. count += push − pop.
- No push (full without pop, or fetch_en=0): fetch_pc held; imem_addr unchanged.
- Redirect (priority over push/pop/fetch_en): count, wr_ptr, rd_ptr <= 0; fetch_pc <= redirect_pc. A pop coinciding with redirect is a completed transfer from decode's view; the entry is discarded with the rest.
- out_valid = (count != 0). out_pc/out_instr = head entry when valid, forced to 0 when empty.
- While out_valid=1 and out_ready=0, out_pc/out_instr/out_valid hold stable.
- Pointers wrap modulo DEPTH.

## Timing

- Reset (rst=1 at edge): fetch_pc=RESET_PC, count=0, pointers 0; out_valid=0, out_pc=0, out_instr=0, fetch_count=0, imem_addr=RESET_PC. rst mid-stream discards all FIFO contents and any redirect that cycle.
- Fetch latency: address presented in cycle N, entry visible (out_valid=1) in cycle N+1.
- Steady state with out_ready=1, fetch_en=1: one instruction per cycle, consecutive pcs, no bubbles.
- Redirect sampled at edge E: out_valid=0 in cycle after E, imem_addr=redirect_pc in that cycle; redirect_pc instruction valid at out one cycle later (exactly one bubble).
- Backpressure: when out_ready=0, FIFO fills to DEPTH after DEPTH cycles, then fetch_pc stalls at the first unfetched address.
- No combinational path from out_ready or redirect_valid to imem_addr.

## Test plan

- Reset then fetch_en=1, out_ready=1, ROM[i]=0xA000_0000+i -> from cycle 1, out_pc=0,1,2,… and out_instr=0xA000_0000,0xA000_0001,… one per cycle.
- out_ready=0 for 8 cycles -> fifo_count reaches 4, imem_addr stalls at 4, out_pc=0 stable; release -> pcs 0..7 delivered in order, no gap, no duplicate.
- Redirect to 0x40 while FIFO holds 3 entries -> next cycle out_valid=0, fifo_count=0; following cycle out_pc=0x40, out_instr=ROM[0x40].
- redirect_pc=0xFE, free-running -> out_pc sequence 0xFE, 0xFF, 0x00, 0x01.
- Full FIFO with out_ready=1 and fetch_en=1 -> fifo_count stays 4, one push and one pop per cycle; toggle fetch_en=0 -> fifo_count drains to 0, imem_addr held.
- Assert rst with FIFO full and redirect_valid=1 simultaneously -> next cycle out_valid=0, imem_addr=RESET_PC, out_pc=0, out_instr=0.
